// File: rtl/seq_compare_if.sv
// Request/response bundle for the multi-cycle magnitude comparator.
// master drives the request; slave (the comparator) returns busy/done/X.
interface seq_compare_if #(
   parameter int unsigned WIDTH = 16
) ();
   logic             start;
   logic [2:0]       mode;
   logic             is_signed;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] X;

   modport master (output start, mode, is_signed, A, B,
                   input  busy, done, X);
   modport slave  (input  start, mode, is_signed, A, B,
                   output busy, done, X);
endinterface

// File: rtl/seq_compare.sv
// Multi-cycle comparator: scans latched operands CHUNK bits per cycle from the MSB,
// stopping at the first unequal chunk; verdict is returned in X[0].
module seq_compare #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 2
) (
   input  logic         clk,
   input  logic         reset,
   seq_compare_if.slave bus
);
   localparam int unsigned N  = WIDTH / CHUNK;
   localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {IDLE, SCAN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, x_q, x_d;
   logic [2:0]       mode_q, mode_d;
   logic [KW-1:0]    k_q, k_d;
   logic             busy_q, busy_d, done_q, done_d;

   function automatic logic relate(input logic [2:0] m, input logic gt, input logic eq);
      case (m)
         3'b000:  relate = eq;
         3'b001:  relate = !eq;
         3'b010:  relate = gt;
         3'b011:  relate = gt | eq;
         3'b100:  relate = !gt & !eq;
         3'b101:  relate = !gt;
         default: relate = 1'b0;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         mode_q  <= '0;
         k_q     <= KW'(N - 1);
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         x_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         mode_q  <= mode_d;
         k_q     <= k_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         x_q     <= x_d;
      end
   end

   // Sign handling is folded in at latch time: flipping the top bit of both
   // operands maps two's-complement order onto unsigned order.
   always_comb begin
      logic [CHUNK-1:0] ca, cb;
      logic             gt, eq, decide;
      int unsigned      lsb;

      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      mode_d  = mode_q;
      k_d     = k_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      x_d     = x_q;
      gt      = 1'b0;
      eq      = 1'b0;
      decide  = 1'b0;
      lsb     = 32'(k_q) * CHUNK;
      ca      = a_q[lsb +: CHUNK];
      cb      = b_q[lsb +: CHUNK];

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d    = bus.A;
               b_d    = bus.B;
               if (bus.is_signed) begin
                  a_d[WIDTH-1] = ~bus.A[WIDTH-1];
                  b_d[WIDTH-1] = ~bus.B[WIDTH-1];
               end
               mode_d  = bus.mode;
               k_d     = KW'(N - 1);
               busy_d  = 1'b1;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (ca != cb) begin
               gt     = (ca > cb);
               decide = 1'b1;
            end else if (k_q == '0) begin
               eq     = 1'b1;
               decide = 1'b1;
            end else begin
               k_d = k_q - KW'(1);
            end
            if (decide) begin
               x_d     = WIDTH'(relate(mode_q, gt, eq));
               done_d  = 1'b1;
               busy_d  = 1'b0;
               k_d     = KW'(N - 1);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.X    = x_q;
endmodule

// File: tb/tb_seq_compare.sv
// Scoreboarded bench for seq_compare: stimulus pushes expected result and done cycle,
// a monitor pops and compares each done pulse.
module tb_seq_compare;
   localparam int unsigned W = 16;
   localparam int unsigned C = 2;
   localparam int unsigned N = W / C;

   typedef struct {
      logic [W-1:0] x;
      int           cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   seq_compare_if #(.WIDTH(W)) bus ();

   seq_compare #(.WIDTH(W), .CHUNK(C)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: relation via integer arithmetic, latency from the highest differing bit.
   function automatic logic ref_rel(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [2:0] m, input bit s);
      int ia, ib;
      ia = s ? int'($signed(a)) : int'(a);
      ib = s ? int'($signed(b)) : int'(b);
      case (m)
         3'd0: return ia == ib;
         3'd1: return ia != ib;
         3'd2: return ia >  ib;
         3'd3: return ia >= ib;
         3'd4: return ia <  ib;
         3'd5: return ia <= ib;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] d;
      d = a ^ b;
      for (int i = W - 1; i >= 0; i--)
         if (d[i]) return (W - 1 - i) / C + 1;
      return N;
   endfunction

   // Drive one request (DUT must be idle); returns just after the accepting edge.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] m, input bit s, input bit track);
      exp_t e;
      bus.A = a; bus.B = b; bus.mode = m; bus.is_signed = s; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (track) begin
         e.x   = W'(ref_rel(a, b, m, s));
         e.cyc = cyc + ref_lat(a, b);
         sb.push_back(e);
      end
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (bus.done !== 1'b1 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (bus.done !== 1'b1) check("done_timeout", 32'(bus.done), 32'd1);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("result_X", 32'(bus.X), 32'(e.x));
               check("done_cycle", 32'(cyc), 32'(e.cyc));
               check("busy_in_done", 32'(bus.busy), 32'd0);
            end
         end
      end
   end

   initial begin
      logic [W-1:0] ra, rb;
      reset = 1'b1;
      bus.start = 1'b0; bus.mode = '0; bus.is_signed = 1'b0; bus.A = '0; bus.B = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_X", 32'(bus.X), 32'd0);

      // Directed cases
      issue(16'h8000, 16'h7FFF, 3'b011, 1'b0, 1'b1); wait_done(20);
      issue(16'h8000, 16'h7FFF, 3'b011, 1'b1, 1'b1); wait_done(20);
      issue(16'h1234, 16'h1234, 3'b011, 1'b0, 1'b1); wait_done(20);
      issue(16'h1234, 16'h1234, 3'b001, 1'b0, 1'b1); wait_done(20);
      issue(16'h1234, 16'h1234, 3'b000, 1'b0, 1'b1); wait_done(20);
      issue(16'h0003, 16'h0002, 3'b100, 1'b0, 1'b1); wait_done(20);
      issue(16'h0003, 16'h0002, 3'b101, 1'b0, 1'b1); wait_done(20);
      issue(16'h0003, 16'h0002, 3'b010, 1'b0, 1'b1); wait_done(20);
      issue(16'hFFFF, 16'h0000, 3'b110, 1'b0, 1'b1); wait_done(20);

      // Starts during a scan are dropped; then back-to-back start in the done cycle
      issue(16'h5555, 16'h5555, 3'b000, 1'b0, 1'b1);
      bus.A = 16'hFFFF; bus.B = 16'h0000; bus.mode = 3'b001; bus.start = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      bus.start = 1'b0;
      wait_done(20);
      issue(16'h00F0, 16'h0010, 3'b010, 1'b1, 1'b1); wait_done(20);
      issue(16'h8001, 16'h8000, 3'b011, 1'b1, 1'b1); wait_done(20);

      // Reset mid-scan: X was 1, must clear and no done may follow
      issue(16'hABCD, 16'hABCD, 3'b000, 1'b0, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_X", 32'(bus.X), 32'd0);
      check("midrst_done", 32'(bus.done), 32'd0);
      repeat (12) @(posedge clk);
      #1;
      issue(16'h0100, 16'h0200, 3'b100, 1'b0, 1'b1); wait_done(20);

      // Random regression with bias toward late and equal decisions
      for (int i = 0; i < 300; i++) begin
         ra = W'($urandom);
         case ($urandom_range(3))
            0:       rb = W'($urandom);
            1:       rb = ra;
            default: rb = ra ^ (W'(1) << $urandom_range(W - 1));
         endcase
         issue(ra, rb, 3'($urandom_range(7)), 1'($urandom_range(1)), 1'b1);
         wait_done(20);
         if ($urandom_range(1) == 1) repeat ($urandom_range(3)) @(posedge clk);
         #1;
      end

      repeat (4) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/seq_compare.md
# seq_compare

Multi-cycle, parametrised magnitude comparator for the ALU. It is the successor to the fixed 6-bit combinational greater-or-equal unit, and extends it in three ways: configurable operand width, six selectable relations, and signed/unsigned operation. It scans the operands CHUNK bits per cycle, MSB-first, and exits early at the first unequal chunk. The result is returned in ALU result format: bit 0 carries the verdict and all upper bits are zero.

## Interface
- WIDTH, 16, operand and result width; must be a multiple of CHUNK.
- CHUNK, 2, bits compared per cycle; N = WIDTH/CHUNK scan steps.
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only while idle.
- mode  in  3  relation: 000 EQ, 001 NE, 010 GT, 011 GTE, 100 LT, 101 LTE, 110/111 reserved.
- is_signed  in  1  1 = two's-complement compare, 0 = unsigned.
- A  in  WIDTH  left operand.
- B  in  WIDTH  right operand.
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle pulse when X is updated.
- X  out  WIDTH  X[0] = relation result, X[WIDTH-1:1] = 0.

## Operation
- FSM has two states: IDLE and SCAN.
- IDLE, start=1 at an edge:
  - Latch A, B, mode, is_signed.
  - Set chunk index k = N-1 (the MSB chunk).
  - Go to SCAN with busy=1.
- Later changes to A, B, mode and is_signed are ignored until the next accepted start.
- SCAN, at each edge, compare latched chunk k of A and B:
  - When is_signed=1, bit WIDTH-1 of both operands is inverted before comparing the MSB chunk, which gives a signed order.
  - If the chunks are unequal, the decision is made: gt = (chunkA > chunkB) and eq = 0.
  - If the chunks are equal and k = 0, the decision is made: gt = 0 and eq = 1.
  - If the chunks are equal and k > 0, decrement k and stay in SCAN.
- On the decision edge:
  - X[0] is registered from mode as follows: EQ = eq; NE = !eq; GT = gt; GTE = gt|eq; LT = !gt&!eq; LTE = !gt.
  - Reserved modes give X[0] = 0 but otherwise behave normally.
  - done=1 and busy=0; the state returns to IDLE.
- X holds its value until the next decision edge or reset.
- start is ignored while busy=1 and is not queued.
- Reset, including mid-scan:
  - Next state is IDLE; busy=0, done=0, X=0.
  - Any in-flight compare is discarded and no done is produced.

## Timing
- Reset values: busy=0, done=0, X=0, state IDLE, k=N-1.
- Start edge = t0; busy is high from the cycle after t0.
- If the first unequal chunk is the j-th from the MSB (j = 0..N-1), the decision edge is t0+j+1.
- If all chunks are equal, the decision edge is t0+N.
- Latency is therefore 1..N cycles.
- done is high for exactly the single cycle after the decision edge; busy is low in that same cycle.
- A start asserted during the done cycle is accepted, since the FSM is in IDLE. This gives back-to-back throughput of one compare per latency+1 cycles.
- reset has priority over start at the same edge.
- There is no combinational path from inputs to outputs.

## Test plan
- WIDTH=16, CHUNK=2, A=0x8000, B=0x7FFF, mode GTE:
  - is_signed=0 -> done at t0+1 with X=0x0001.
  - is_signed=1 -> done at t0+1 with X=0x0000.
- A=B=0x1234 -> done at t0+8 for every mode:
  - GTE -> X=0x0001.
  - NE -> X=0x0000.
  - EQ -> X=0x0001.
- A=0x0003, B=0x0002, mode LT -> decision at the LSB chunk, done at t0+8, X=0x0000; the same operands with LTE also give X=0x0000, and with GT give X=0x0001.
- Handshake:
  - start pulsed again at t0+1 and t0+2 with different operands -> ignored; result reflects the first operands only.
  - start in the done cycle -> accepted; the second result follows with correct latency.
- Reset asserted at t0+3 of a full-length scan (A=B) -> busy=0 and X=0 on the following cycle; done never pulses. A new start after reset completes normally.
- mode=110 with A=0xFFFF, B=0x0000 -> done at t0+1 with X=0x0000. Also run a random regression over all modes and both signedness settings against a reference model, checking that X[15:1] is always 0.
